// File: rtl/uart_rx.sv
// Multi-word UART receiver: deserialises NUM_WORDS inverted, LSB-first packets
// from a 2-flop synchronised line and presents the reassembled beat on valid/ready.
module uart_rx #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE      = BITS_PER_WORD + 5,
  parameter int W_OUT            = 24,
  localparam int NUM_WORDS       = W_OUT / BITS_PER_WORD
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      rx,
  output logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]   m_data,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic                                      frame_err,
  output logic                                      overrun
);

  // Handshake: the beat in m_data transfers on any cycle where m_valid && m_ready;
  // m_data never changes while m_valid is high and no transfer occurs.

  localparam int CW    = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BW    = $clog2(PACKET_SIZE);
  localparam int WIW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int NSTOP = PACKET_SIZE - BITS_PER_WORD - 1;

  localparam logic [CW-1:0]  HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0]  FULL_LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(BITS_PER_WORD - 1);
  localparam logic [BW-1:0]  STOP_LAST = BW'(NSTOP - 1);
  localparam logic [WIW-1:0] WORD_LAST = WIW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                                   state_q, state_d;
  logic                                     rx_meta_q, rx_s_q;
  logic [CW-1:0]                            clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]                            bit_cnt_q, bit_cnt_d;
  logic [WIW-1:0]                           word_idx_q, word_idx_d;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  asm_q, asm_d;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  m_data_q, m_data_d;
  logic                                     m_valid_q, m_valid_d;
  logic                                     frame_err_q, frame_err_d;
  logic                                     overrun_q, overrun_d;
  logic                                     beat_done;

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_idx_d  = word_idx_q;
    asm_d       = asm_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    beat_done   = 1'b0;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          clk_cnt_d = '0;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d = '0;
          // Shift in from the top so LSB-first bits land in place after the last one.
          for (int w = 0; w < NUM_WORDS; w++) begin
            if (int'(word_idx_q) == w)
              asm_d[w] = {~rx_s_q, asm_q[w][BITS_PER_WORD-1:1]};
          end
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = S_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d = '0;
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            word_idx_d  = '0;
            bit_cnt_d   = '0;
            state_d     = S_IDLE;
          end else if (bit_cnt_q == STOP_LAST) begin
            // Leave at the mid-point of the final stop bit so a zero-gap start is caught.
            bit_cnt_d = '0;
            state_d   = S_IDLE;
            if (word_idx_q == WORD_LAST) begin
              word_idx_d = '0;
              beat_done  = 1'b1;
            end else begin
              word_idx_d = word_idx_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (beat_done) begin
      if (!m_valid_q || m_ready) begin
        m_data_d  = asm_q;
        m_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      word_idx_q  <= '0;
      asm_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      word_idx_q  <= word_idx_d;
      asm_q       <= asm_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx (16-bit beats, 4 clocks per bit): drives framed wire packets,
// checks received beats and error pulses against what was sent.
module tb_uart_rx;
  localparam int CPP = 4;
  localparam int BPW = 8;
  localparam int PS  = BPW + 5;
  localparam int W   = 16;
  localparam int NW  = W / BPW;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    rx = 1'b1;
  logic                    m_ready = 1'b1;
  logic [NW-1:0][BPW-1:0]  m_data;
  logic                    m_valid;
  logic                    frame_err;
  logic                    overrun;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vld_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  uart_rx #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD(BPW),
    .PACKET_SIZE(PS),
    .W_OUT(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Observer: collects accepted beats and counts pulses, sampled mid low phase.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (m_valid) vld_cyc++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  // Wire frame: start 0, data inverted LSB first, then stop/padding 1s.
  task automatic send_word(input logic [BPW-1:0] d, input int bad_bit, input int nbits);
    logic [PS-1:0] frame;
    frame = '1;
    frame[0] = 1'b0;
    for (int i = 0; i < BPW; i++) frame[1+i] = ~d[i];
    if (bad_bit >= 0) frame[bad_bit] = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      rx = frame[k];
      repeat (CPP) @(negedge clk);
    end
  endtask

  task automatic send_beat(input logic [W-1:0] b);
    for (int i = 0; i < NW; i++) send_word(b[i*BPW +: BPW], -1, PS);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL reset_m_data: got %h expected 0000", m_data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int fe0, ov0, v0, lat;
    logic [W-1:0] cap;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cyc; lat = 0; cap = '0;
    m_ready = 1'b1;
    send_word(8'hA5, -1, PS);
    send_word(8'h3C, -1, PS - 1);
    rx = 1'b1;
    // Final stop bit mid-point is 2 clocks in; m_valid follows 3 clocks later.
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin lat = n; cap = m_data; break; end
    end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    n_cmp++; if (cap !== 16'h3CA5) begin n_err++; $display("FAIL basic_data: got %h expected 3ca5", cap); end
    repeat (4) @(negedge clk);
    n_cmp++; if (vld_cyc - v0 !== 1) begin n_err++; $display("FAIL basic_valid_cycles: got %0d expected 1", vld_cyc - v0); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL basic_frame_err: got %0d expected 0", fe_cnt - fe0); end
    n_cmp++; if (ov_cnt - ov0 !== 0) begin n_err++; $display("FAIL basic_overrun: got %0d expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_glitch();
    int fe0, v0;
    fe0 = fe_cnt; v0 = vld_cyc;
    got_q.delete();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++; if (vld_cyc - v0 !== 0) begin n_err++; $display("FAIL glitch_valid: got %0d expected 0", vld_cyc - v0); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - fe0); end
    send_beat(16'h1234);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 16'h1234) begin
      n_err++; $display("FAIL glitch_next_beat: got %0d beats first %h expected 1 beat 1234", got_q.size(), got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
  endtask

  task automatic check_stream(input string name, input int fe0, input int ov0);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL %s_count: got %0d expected %0d", name, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL %s_beat%0d: got %h expected %h", name, i, i < got_q.size() ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL %s_frame_err: got %0d expected 0", name, fe_cnt - fe0); end
    n_cmp++; if (ov_cnt - ov0 !== 0) begin n_err++; $display("FAIL %s_overrun: got %0d expected 0", name, ov_cnt - ov0); end
  endtask

  task automatic test_back_to_back();
    int fe0, ov0;
    logic [W-1:0] b;
    fe0 = fe_cnt; ov0 = ov_cnt;
    got_q.delete(); exp_q.delete();
    m_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      b = 16'($urandom_range(0, 65535));
      exp_q.push_back(b);
      send_beat(b);
    end
    repeat (6) @(negedge clk);
    check_stream("b2b", fe0, ov0);
  endtask

  task automatic test_random_gaps();
    int fe0, ov0;
    logic [W-1:0] b;
    fe0 = fe_cnt; ov0 = ov_cnt;
    got_q.delete(); exp_q.delete();
    for (int n = 0; n < 5; n++) begin
      b = 16'($urandom_range(0, 65535));
      exp_q.push_back(b);
      for (int i = 0; i < NW; i++) begin
        send_word(b[i*BPW +: BPW], -1, PS);
        repeat ($urandom_range(0, 15)) @(negedge clk);
      end
    end
    repeat (6) @(negedge clk);
    check_stream("gaps", fe0, ov0);
  endtask

  task automatic test_frame_err();
    int fe0, v0;
    fe0 = fe_cnt; v0 = vld_cyc;
    got_q.delete();
    send_word(8'h55, -1, PS);
    send_word(8'h66, BPW + 2, PS);
    repeat (4) @(negedge clk);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL frame_err_pulses: got %0d expected 1", fe_cnt - fe0); end
    n_cmp++; if (vld_cyc - v0 !== 0) begin n_err++; $display("FAIL frame_err_no_valid: got %0d expected 0", vld_cyc - v0); end
    send_beat(16'hBEEF);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 16'hBEEF) begin
      n_err++; $display("FAIL frame_err_next_beat: got %0d beats first %h expected 1 beat beef", got_q.size(), got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL frame_err_after: got %0d expected 1", fe_cnt - fe0); end
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    got_q.delete();
    m_ready = 1'b0;
    send_beat(16'h1111);
    send_beat(16'h2222);
    repeat (6) @(negedge clk);
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL overrun_held_valid: got %b expected 1", m_valid); end
    n_cmp++; if (m_data !== 16'h1111) begin n_err++; $display("FAIL overrun_held_data: got %h expected 1111", m_data); end
    n_cmp++; if (ov_cnt - ov0 !== 1) begin n_err++; $display("FAIL overrun_pulses: got %0d expected 1", ov_cnt - ov0); end
    m_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL overrun_valid_clear: got %b expected 0", m_valid); end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 16'h1111) begin
      n_err++; $display("FAIL overrun_accepted: got %0d beats first %h expected 1 beat 1111", got_q.size(), got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_reset_mid();
    int fe0;
    m_ready = 1'b0;
    send_beat(16'hAAAA);
    repeat (6) @(negedge clk);
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_held: got %b expected 1", m_valid); end
    send_word(8'h11, -1, PS);
    send_word(8'h22, -1, 4);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_m_valid: got %b expected 0", m_valid); end
    n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL rstmid_m_data: got %h expected 0000", m_data); end
    n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL rstmid_pulses: got %b%b expected 00", frame_err, overrun); end
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (8) @(negedge clk);
    got_q.delete();
    fe0 = fe_cnt;
    send_beat(16'h00FF);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 16'h00FF) begin
      n_err++; $display("FAIL rstmid_next_beat: got %0d beats first %h expected 1 beat 00ff", got_q.size(), got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL rstmid_frame_err: got %0d expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_break();
    int fe0, ov0, v0;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cyc;
    // Each break "packet" is re-detected from IDLE, so errors recur about every 39 clocks.
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (fe_cnt - fe0 !== 2) begin n_err++; $display("FAIL break_frame_err: got %0d expected 2", fe_cnt - fe0); end
    n_cmp++; if (vld_cyc - v0 !== 0) begin n_err++; $display("FAIL break_valid: got %0d expected 0", vld_cyc - v0); end
    n_cmp++; if (ov_cnt - ov0 !== 0) begin n_err++; $display("FAIL break_overrun: got %0d expected 0", ov_cnt - ov0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_random_gaps();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_break();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
